// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg
// Shared MIPS encoding constants used by both the opcode decoder and the
// instruction-memory loader, so that the two directions cannot drift apart.
// Contents:
//   - OP_*   : 6-bit primary opcodes
//   - KIND_* : loader description kinds (values 11-15 are illegal)
//   - loader_state_t : loader FSM state encoding
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] KIND_RTYPE = 4'd0;
  localparam logic [3:0] KIND_LW    = 4'd1;
  localparam logic [3:0] KIND_SW    = 4'd2;
  localparam logic [3:0] KIND_BEQ   = 4'd3;
  localparam logic [3:0] KIND_BNE   = 4'd4;
  localparam logic [3:0] KIND_ADDI  = 4'd5;
  localparam logic [3:0] KIND_SLTI  = 4'd6;
  localparam logic [3:0] KIND_ANDI  = 4'd7;
  localparam logic [3:0] KIND_ORI   = 4'd8;
  localparam logic [3:0] KIND_XORI  = 4'd9;
  localparam logic [3:0] KIND_J     = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack
// Purely combinational packer: turns a field-level instruction description
// into a 32-bit MIPS word and flags whether the kind code is legal.
// Ports:
//   kind   in  4   description kind (KIND_*)
//   rs,rt,rd,shamt in 5  register / shift fields
//   funct  in  6   R-type function field
//   imm    in  16  I-type immediate / branch offset
//   target in  26  J-type target
//   word   out 32  packed instruction (0 when illegal)
//   legal  out 1   kind is one of the defined codes
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind)
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:    word = {OP_LW,   rs, rt, imm};
      KIND_SW:    word = {OP_SW,   rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ,  rs, rt, imm};
      KIND_BNE:   word = {OP_BNE,  rs, rt, imm};
      KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
      KIND_SLTI:  word = {OP_SLTI, rs, rt, imm};
      KIND_ANDI:  word = {OP_ANDI, rs, rt, imm};
      KIND_ORI:   word = {OP_ORI,  rs, rt, imm};
      KIND_XORI:  word = {OP_XORI, rs, rt, imm};
      KIND_J:     word = {OP_J, target};
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Loads a program into instruction memory before the CPU runs. Field-level
// descriptions arrive on a valid/ready stream, are packed into MIPS words
// and written to consecutive imem words starting at word 0.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               pulse: begin/restart a session at word 0
//   i_valid / o_ready     description handshake
//   i_last                marks the final description
//   i_kind, i_rs, i_rt, i_rd, i_shamt, i_funct, i_imm, i_target  fields
//   o_imem_we/addr/wdata  imem write port (byte address)
//   o_count               words written this session
//   o_full                o_count == IMEM_DEPTH
//   o_err                 sticky illegal-kind flag
//   o_done                session finished, held until next i_start
module instr_mem_loader
  import mips_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int CNT_W      = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_last,
  input  logic [3:0]       i_kind,
  input  logic [4:0]       i_rs,
  input  logic [4:0]       i_rt,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_shamt,
  input  logic [5:0]       i_funct,
  input  logic [15:0]      i_imm,
  input  logic [25:0]      i_target,
  output logic             o_imem_we,
  output logic [31:0]      o_imem_addr,
  output logic [31:0]      o_imem_wdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_err,
  output logic             o_done
);

  loader_state_t    state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic             we_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic             err_reg;
  logic             last_pend_reg;  // accepted description carried i_last

  logic [31:0] packed_word;
  logic        packed_legal;
  logic        accept;

  instr_field_pack u_pack (
    .kind   (i_kind),
    .rs     (i_rs),
    .rt     (i_rt),
    .rd     (i_rd),
    .shamt  (i_shamt),
    .funct  (i_funct),
    .imm    (i_imm),
    .target (i_target),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign o_full  = (count_reg == CNT_W'(IMEM_DEPTH));
  // A restart cycle never accepts, and nothing is accepted while reset is held.
  assign o_ready = (state_reg == ST_LOAD) && !o_full && !i_start && !i_rst;
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_start) state_next = ST_LOAD;
      ST_LOAD: begin
        // DONE is entered the cycle after the final word's write strobe.
        if (i_start)            state_next = ST_LOAD;
        else if (last_pend_reg) state_next = ST_DONE;
      end
      ST_DONE: if (i_start) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      last_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= accept && packed_legal;
      last_pend_reg <= accept && i_last;
      if (accept && packed_legal) begin
        addr_reg  <= 32'(count_reg) << 2;
        wdata_reg <= packed_word;
      end
      if (i_start) begin
        count_reg <= '0;
        err_reg   <= 1'b0;
      end else if (accept) begin
        if (packed_legal) count_reg <= count_reg + CNT_W'(1);
        else              err_reg   <= 1'b1;
      end
    end
  end

  // Reset arriving while a write is in flight suppresses that strobe.
  assign o_imem_we    = we_reg && !i_rst;
  assign o_imem_addr  = addr_reg;
  assign o_imem_wdata = wdata_reg;
  assign o_count      = count_reg;
  assign o_err        = err_reg;
  assign o_done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader (IMEM_DEPTH=4). Hand-written
// sequences cover the multi-cycle corner cases; a table of single-word
// sessions covers every packing format. A scoreboard queue holds the
// expected {addr, word} of each accepted legal description and is checked
// against every imem write strobe.
module tb_instr_mem_loader;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1, i_start = 1'b0, i_valid = 1'b0, i_last = 1'b0;
  logic [3:0]    i_kind = '0;
  logic [4:0]    i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;
  logic [5:0]    i_funct = '0;
  logic [15:0]   i_imm = '0;
  logic [25:0]   i_target = '0;
  logic          o_ready, o_imem_we, o_full, o_err, o_done;
  logic [31:0]   o_imem_addr, o_imem_wdata;
  logic [CW-1:0] o_count;

  always #5 clk = ~clk;

  instr_mem_loader #(.IMEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
    .o_ready(o_ready), .i_last(i_last), .i_kind(i_kind), .i_rs(i_rs),
    .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt), .i_funct(i_funct),
    .i_imm(i_imm), .i_target(i_target), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_count(o_count), .o_full(o_full), .o_err(o_err), .o_done(o_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected word and legality of the description currently driven.
  logic [31:0] drv_word  = '0;
  logic        drv_legal = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb_q[$];
  int  model_cnt = 0;

  // Scoreboard: pop on write strobe, push on accepted legal description.
  always @(negedge clk) begin
    wr_t e;
    if (i_rst) begin
      sb_q.delete();
      model_cnt = 0;
    end else begin
      if (o_imem_we) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%h data=%h required no write",
                   o_imem_addr, o_imem_wdata);
        end else begin
          e = sb_q.pop_front();
          chk("sb_addr", o_imem_addr, e.addr);
          chk("sb_wdata", o_imem_wdata, e.data);
          $display("write addr=%h data=%h expected addr=%h data=%h",
                   o_imem_addr, o_imem_wdata, e.addr, e.data);
        end
      end
      if (i_start) model_cnt = 0;
      else if (i_valid && o_ready && drv_legal) begin
        e.addr = 32'(model_cnt) * 4;
        e.data = drv_word;
        sb_q.push_back(e);
        model_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tg, input logic last,
                       input logic [31:0] w, input logic lg);
    i_valid = 1'b1; i_kind = k; i_rs = rs; i_rt = rt; i_rd = rd; i_shamt = sh;
    i_funct = fn; i_imm = imm; i_target = tg; i_last = last;
    drv_word = w; drv_legal = lg;
  endtask

  task automatic idle_in();
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    settle();
    chk("ready_in_start", 32'(o_ready), 32'd0);
    step();
    i_start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tg;
    logic [31:0] word;
    logic        legal;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // kind rs rt rd sh fn imm tg word legal
    vecs[0]  = '{4'd5,  5'd0,  5'd8,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h20080005, 1'b1};
    vecs[1]  = '{4'd0,  5'd8,  5'd9,  5'd10, 5'd0,  6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h01095020, 1'b1};
    vecs[2]  = '{4'd10, 5'd7,  5'd7,  5'd7,  5'd7,  6'h3F, 16'h1234, 26'h0000010, 32'h08000010, 1'b1};
    vecs[3]  = '{4'd1,  5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8FA80004, 1'b1};
    vecs[4]  = '{4'd2,  5'd29, 5'd31, 5'd3,  5'd0,  6'h00, 16'hFFFC, 26'h0,       32'hAFBFFFFC, 1'b1};
    vecs[5]  = '{4'd3,  5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h1022FFFF, 1'b1};
    vecs[6]  = '{4'd4,  5'd3,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0,       32'h14600010, 1'b1};
    vecs[7]  = '{4'd6,  5'd4,  5'd5,  5'd0,  5'd0,  6'h00, 16'h0007, 26'h0,       32'h28850007, 1'b1};
    vecs[8]  = '{4'd7,  5'd6,  5'd7,  5'd0,  5'd0,  6'h00, 16'h00FF, 26'h0,       32'h30C700FF, 1'b1};
    vecs[9]  = '{4'd8,  5'd0,  5'd1,  5'd0,  5'd0,  6'h00, 16'h1234, 26'h0,       32'h34011234, 1'b1};
    vecs[10] = '{4'd9,  5'd2,  5'd3,  5'd0,  5'd0,  6'h00, 16'hABCD, 26'h0,       32'h3843ABCD, 1'b1};
    vecs[11] = '{4'd0,  5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0,    26'h0,       32'h03FFFFFF, 1'b1};
    vecs[12] = '{4'd10, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0,    26'h3FFFFFF, 32'h0BFFFFFF, 1'b1};
    vecs[13] = '{4'd15, 5'd1,  5'd1,  5'd1,  5'd1,  6'h01, 16'h1,    26'h1,       32'h00000000, 1'b0};

    // Reset state
    step(); step();
    chk("rst_we", 32'(o_imem_we), 32'd0);
    chk("rst_addr", o_imem_addr, 32'd0);
    chk("rst_wdata", o_imem_wdata, 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_flags", {28'd0, o_full, o_err, o_done, o_ready}, 32'd0);
    i_rst = 1'b0;
    step();
    chk("idle_ready", 32'(o_ready), 32'd0);

    // First ADDI: write lands one cycle after accept
    do_start();
    drive(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0, 32'h20080005, 1'b1);
    settle();
    chk("addi_ready", 32'(o_ready), 32'd1);
    step();
    idle_in();
    chk("addi_we", 32'(o_imem_we), 32'd1);
    chk("addi_addr", o_imem_addr, 32'd0);
    chk("addi_wdata", o_imem_wdata, 32'h20080005);
    chk("addi_count", 32'(o_count), 32'd1);
    step();
    chk("addi_we_pulse", 32'(o_imem_we), 32'd0);
    chk("addi_hold_wdata", o_imem_wdata, 32'h20080005);

    // Back-to-back R then J(last); done two cycles after second accept
    do_start();
    drive(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, 32'h01095020, 1'b1);
    step();
    drive(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1'b1, 32'h08000010, 1'b1);
    chk("b2b_r_wdata", o_imem_wdata, 32'h01095020);
    step();
    idle_in();
    chk("b2b_j_we", 32'(o_imem_we), 32'd1);
    chk("b2b_j_addr", o_imem_addr, 32'd4);
    chk("b2b_count", 32'(o_count), 32'd2);
    chk("b2b_done_early", 32'(o_done), 32'd0);
    step();
    chk("b2b_done", 32'(o_done), 32'd1);
    chk("b2b_done_ready", 32'(o_ready), 32'd0);
    step();
    chk("b2b_done_held", 32'(o_done), 32'd1);

    // Illegal kind then LW at same address
    do_start();
    chk("start_clears_done", 32'(o_done), 32'd0);
    drive(4'd12, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0, 32'h8FA80004, 1'b1);
    chk("ill_we", 32'(o_imem_we), 32'd0);
    chk("ill_err", 32'(o_err), 32'd1);
    chk("ill_count", 32'(o_count), 32'd0);
    step();
    idle_in();
    chk("lw_addr", o_imem_addr, 32'd0);
    chk("lw_wdata", o_imem_wdata, 32'h8FA80004);
    chk("lw_err_sticky", 32'(o_err), 32'd1);

    // Fill to DEPTH without last
    do_start();
    chk("start_clears_err", 32'(o_err), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      drive(4'd5, 5'd0, 5'(k + 1), 5'd0, 5'd0, 6'h0, 16'(k + 16), 26'h0, 1'b0,
            {6'b001000, 5'd0, 5'(k + 1), 16'(k + 16)}, 1'b1);
      step();
    end
    settle();
    chk("full_flag", 32'(o_full), 32'd1);
    chk("full_ready", 32'(o_ready), 32'd0);
    chk("full_count", 32'(o_count), 32'(DEPTH));
    step();
    chk("full_no_we", 32'(o_imem_we), 32'd0);
    step();
    chk("full_no_done", 32'(o_done), 32'd0);
    chk("full_count_hold", 32'(o_count), 32'(DEPTH));
    idle_in();

    // Restart mid-session after an illegal and three words
    do_start();
    drive(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(4'd8, 5'd1, 5'(k), 5'd0, 5'd0, 6'h0, 16'(k), 26'h0, 1'b0,
            {6'b001101, 5'd1, 5'(k), 16'(k)}, 1'b1);
      step();
    end
    drive(4'd9, 5'd4, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00AA, 26'h0, 1'b0, 32'h388400AA, 1'b1);
    i_start = 1'b1;
    settle();
    chk("restart_ready", 32'(o_ready), 32'd0);
    chk("restart_pending_we", 32'(o_imem_we), 32'd1);
    chk("restart_pending_addr", o_imem_addr, 32'd8);
    chk("restart_pre_count", 32'(o_count), 32'd3);
    chk("restart_pre_err", 32'(o_err), 32'd1);
    step();
    i_start = 1'b0;
    chk("restart_count", 32'(o_count), 32'd0);
    chk("restart_err", 32'(o_err), 32'd0);
    chk("restart_no_we", 32'(o_imem_we), 32'd0);
    step();
    idle_in();
    chk("restart_addr0", o_imem_addr, 32'd0);
    chk("restart_wdata", o_imem_wdata, 32'h388400AA);

    // Reset the cycle after an accept drops the write
    do_start();
    drive(4'd5, 5'd3, 5'd3, 5'd0, 5'd0, 6'h0, 16'h7777, 26'h0, 1'b0, 32'h20637777, 1'b1);
    step();
    idle_in();
    i_rst = 1'b1;
    settle();
    chk("rstmid_we", 32'(o_imem_we), 32'd0);
    step();
    chk("rstmid_addr", o_imem_addr, 32'd0);
    chk("rstmid_wdata", o_imem_wdata, 32'd0);
    chk("rstmid_count", 32'(o_count), 32'd0);
    chk("rstmid_flags", {28'd0, o_full, o_err, o_done, o_ready}, 32'd0);
    i_rst = 1'b0;
    drive(4'd5, 5'd3, 5'd3, 5'd0, 5'd0, 6'h0, 16'h7777, 26'h0, 1'b0, 32'h20637777, 1'b1);
    step();
    chk("rstmid_idle_ready", 32'(o_ready), 32'd0);
    chk("rstmid_idle_we", 32'(o_imem_we), 32'd0);
    idle_in();

    // Table: one single-word session per packing format
    foreach (vecs[i]) begin
      do_start();
      drive(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].fn,
            vecs[i].imm, vecs[i].tg, 1'b1, vecs[i].word, vecs[i].legal);
      step();
      idle_in();
      chk($sformatf("vec%0d_we", i), 32'(o_imem_we), 32'(vecs[i].legal));
      chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].legal));
      chk($sformatf("vec%0d_err", i), 32'(o_err), 32'(!vecs[i].legal));
      if (vecs[i].legal)
        chk($sformatf("vec%0d_wdata", i), o_imem_wdata, vecs[i].word);
      step();
      chk($sformatf("vec%0d_done", i), 32'(o_done), 32'd1);
    end

    step(); step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
